// File: rtl/rv_pkg.sv
// ----------------------------------------------------------------------------
// rv_pkg -- shared RV32I decode constants and types for the ID stage.
//
// Contents:
//   OPC_OP, OPC_OP_IMM       major opcodes handled by the ALU path
//   FUNCT7_BASE, FUNCT7_ALT  funct7 encodings (base / SUB-SRA variant)
//   F3_*                     funct3 ALU operation selects
//   id_bundle_t              decoded bundle carried from decode to output reg
//   op_legal, op_imm_legal   funct7/funct3 legality rules per opcode
//
// Configuration: the legality helpers are only referenced when the macro
// ID_ILLEGAL_CHECK_EN is defined.
// ----------------------------------------------------------------------------
package rv_pkg;

  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM  = 7'b0010011;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  typedef struct packed {
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic        rd_we;
    logic        use_imm;
    logic [31:0] imm;
    logic [2:0]  funct3;
    logic        op_type;
    logic [4:0]  shamt;
    logic        shamt_from_rs2;
    logic        illegal;
  } id_bundle_t;

  // Register-register ops: only ADD/SUB and SRL/SRA have an alternate funct7.
  function automatic logic op_legal(input logic [6:0] funct7, input logic [2:0] funct3);
    logic ok;
    if (funct7 == FUNCT7_BASE) begin
      ok = 1'b1;
    end else if (funct7 == FUNCT7_ALT) begin
      ok = (funct3 == F3_ADD) || (funct3 == F3_SR);
    end else begin
      ok = 1'b0;
    end
    return ok;
  endfunction

  // Immediate ops: funct7 only matters for the shifts, where it overlays imm.
  function automatic logic op_imm_legal(input logic [6:0] funct7, input logic [2:0] funct3);
    logic ok;
    case (funct3)
      F3_SLL:  ok = (funct7 == FUNCT7_BASE);
      F3_SR:   ok = (funct7 == FUNCT7_BASE) || (funct7 == FUNCT7_ALT);
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/id_decode.sv
// ----------------------------------------------------------------------------
// id_decode -- purely combinational RV32I ALU-instruction decoder.
//
// Ports:
//   instr_i  in  32  instruction word
//   dec_o    out     decoded bundle (register indices, immediate, ALU
//                    controls, writeback enable, illegal flag)
//
// Configuration: ID_ILLEGAL_CHECK_EN enables full opcode/funct7 legality
// checking. Without it, instr[5] alone picks OP (1) vs OP-IMM (0) and every
// instruction is reported legal.
// ----------------------------------------------------------------------------
module id_decode
  import rv_pkg::*;
(
  input  logic [31:0] instr_i,
  output id_bundle_t  dec_o
);

  logic [6:0] funct7_s;
  logic [2:0] funct3_s;
  logic       legal_s;

  assign funct7_s = instr_i[31:25];
  assign funct3_s = instr_i[14:12];

`ifndef ID_ILLEGAL_CHECK_EN
  // Opcode bits other than instr[5] do not influence decode in this build.
  logic unused_opc_s;
  assign unused_opc_s = ^{instr_i[6], instr_i[4:0]};
`endif

  // Field extraction, operand selection and legality.
  always_comb begin
    dec_o                = '0;
    dec_o.rs1_addr       = instr_i[19:15];
    dec_o.rs2_addr       = instr_i[24:20];
    dec_o.rd_addr        = instr_i[11:7];
    dec_o.imm            = {{20{instr_i[31]}}, instr_i[31:20]};
    dec_o.funct3         = funct3_s;
    dec_o.shamt          = instr_i[24:20];
    legal_s              = 1'b1;
`ifdef ID_ILLEGAL_CHECK_EN
    case (instr_i[6:0])
      OPC_OP: begin
        dec_o.use_imm        = 1'b0;
        dec_o.shamt_from_rs2 = 1'b1;
        dec_o.op_type        = instr_i[30];
        legal_s              = op_legal(funct7_s, funct3_s);
      end
      OPC_OP_IMM: begin
        dec_o.use_imm        = 1'b1;
        dec_o.shamt_from_rs2 = 1'b0;
        // instr[30] is an immediate bit except for SRLI/SRAI
        dec_o.op_type        = (funct3_s == F3_SR) ? instr_i[30] : 1'b0;
        legal_s              = op_imm_legal(funct7_s, funct3_s);
      end
      default: begin
        dec_o.use_imm        = 1'b0;
        dec_o.shamt_from_rs2 = 1'b0;
        dec_o.op_type        = 1'b0;
        legal_s              = 1'b0;
      end
    endcase
`else
    if (instr_i[5]) begin
      dec_o.use_imm        = 1'b0;
      dec_o.shamt_from_rs2 = 1'b1;
      dec_o.op_type        = instr_i[30];
    end else begin
      dec_o.use_imm        = 1'b1;
      dec_o.shamt_from_rs2 = 1'b0;
      dec_o.op_type        = (funct3_s == F3_SR) ? instr_i[30] : 1'b0;
    end
    legal_s = (funct7_s == funct7_s);
`endif
    dec_o.illegal = !legal_s;
    dec_o.rd_we   = legal_s && (instr_i[11:7] != 5'd0);
  end

endmodule

// File: rtl/id_stage.sv
// ----------------------------------------------------------------------------
// id_stage -- RV32I decode pipeline stage with valid/ready handshake.
//
// Ports:
//   clk_i, rst_i              clock, asynchronous active-high reset
//   flush_i                   drop held bundle and this cycle's input
//   in_valid_i / in_ready_o   upstream handshake (in_ready_o combinational)
//   instr_i, pc_i             instruction word and its PC
//   out_valid_o / out_ready_i downstream handshake
//   out_pc_o                  registered PC
//   rs1/rs2/rd_addr_o         register indices
//   rd_we_o                   writeback enable
//   use_imm_o, imm_o          ALU operand2 select and sign-extended immediate
//   funct3_o, op_type_o       ALU operation and SUB/SRA select
//   shamt_o, shamt_from_rs2_o shift amount and its source
//   illegal_o                 unsupported instruction
//
// Configuration: ID_ILLEGAL_CHECK_EN (see id_decode) enables legality checks.
// All outputs except in_ready_o are registered and hold while stalled.
// ----------------------------------------------------------------------------
module id_stage
  import rv_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_pc_o,
  output logic [4:0]  rs1_addr_o,
  output logic [4:0]  rs2_addr_o,
  output logic [4:0]  rd_addr_o,
  output logic        rd_we_o,
  output logic        use_imm_o,
  output logic [31:0] imm_o,
  output logic [2:0]  funct3_o,
  output logic        op_type_o,
  output logic [4:0]  shamt_o,
  output logic        shamt_from_rs2_o,
  output logic        illegal_o
);

  id_bundle_t  dec_s;
  id_bundle_t  bundle_r;
  logic [31:0] pc_r;
  logic        out_valid_r;
  logic        take_s;

  id_decode u_decode (
    .instr_i (instr_i),
    .dec_o   (dec_s)
  );

  assign in_ready_o = !out_valid_r || out_ready_i;
  // Flush suppresses the load so the incoming instruction is discarded.
  assign take_s     = in_valid_i && in_ready_o && !flush_i;

  // Output valid flag: flush > load > downstream accept.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_r <= 1'b0;
    end else if (flush_i) begin
      out_valid_r <= 1'b0;
    end else if (take_s) begin
      out_valid_r <= 1'b1;
    end else if (out_ready_i) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  // Payload register: only loads on a transfer in, so it holds while stalled.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bundle_r <= '0;
      pc_r     <= 32'h0000_0000;
    end else if (take_s) begin
      bundle_r <= dec_s;
      pc_r     <= pc_i;
    end else begin
      bundle_r <= bundle_r;
      pc_r     <= pc_r;
    end
  end

  assign out_valid_o      = out_valid_r;
  assign out_pc_o         = pc_r;
  assign rs1_addr_o       = bundle_r.rs1_addr;
  assign rs2_addr_o       = bundle_r.rs2_addr;
  assign rd_addr_o        = bundle_r.rd_addr;
  assign rd_we_o          = bundle_r.rd_we;
  assign use_imm_o        = bundle_r.use_imm;
  assign imm_o            = bundle_r.imm;
  assign funct3_o         = bundle_r.funct3;
  assign op_type_o        = bundle_r.op_type;
  assign shamt_o          = bundle_r.shamt;
  assign shamt_from_rs2_o = bundle_r.shamt_from_rs2;
  assign illegal_o        = bundle_r.illegal;

endmodule
